// File: rtl/conv_window_gen_if.sv
// Stream interface for conv_window_gen: pixel input handshake and window
// output handshake. The WIN_POS_EN macro adds the window-position fields
// (and the image-size parameters they need).
interface conv_window_gen_if #(
    parameter int IN_DATA_WIDTH = 9,
    parameter int K_H           = 3,
    parameter int K_W           = 3
`ifdef WIN_POS_EN
    ,
    parameter int IMG_W         = 16,
    parameter int IMG_H         = 16
`endif
);
    logic [IN_DATA_WIDTH-1:0]         in_pixel;
    logic                             in_valid;
    logic                             in_ready;
    logic [K_H*K_W*IN_DATA_WIDTH-1:0] win_out;
    logic                             win_valid;
    logic                             win_ready;
`ifdef WIN_POS_EN
    logic [$clog2(IMG_H)-1:0]         win_row;
    logic [$clog2(IMG_W)-1:0]         win_col;

    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win_out, win_valid, win_row, win_col
    );
    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win_out, win_valid, win_row, win_col
    );
`else
    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win_out, win_valid
    );
    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win_out, win_valid
    );
`endif
endinterface

// File: rtl/conv_window_gen.sv
// Sliding-window generator: buffers K_H-1 image rows and emits every fully
// populated K_H x K_W window (stride 1, no padding) as one registered bus
// with a valid/ready handshake. Element [r][c] of win_out sits at bit
// (r*K_W+c)*IN_DATA_WIDTH; r=0 is the oldest row, c=0 the leftmost column.
// Optional macro WIN_POS_EN adds the registered top-left coordinate of
// each window (win_row / win_col on the interface).
module conv_window_gen #(
    parameter int IN_DATA_WIDTH = 9,
    parameter int IMG_W         = 16,
    parameter int IMG_H         = 16,
    parameter int K_H           = 3,
    parameter int K_W           = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    conv_window_gen_if.slave   bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int WIN_W = K_H * K_W * IN_DATA_WIDTH;

    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(K_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ROW_W-1:0]         row;
    logic [COL_W-1:0]         col;
    logic                     accept;
    logic                     last_pixel;
    logic                     win_fire;
    logic                     win_take;

    // line_buf[0] holds the oldest stored row, line_buf[K_H-2] the newest.
    logic [IN_DATA_WIDTH-1:0] line_buf [K_H-1][IMG_W];
    logic [IN_DATA_WIDTH-1:0] win_sr   [K_H][K_W];
    logic [IN_DATA_WIDTH-1:0] win_nxt  [K_H][K_W];
    logic [IN_DATA_WIDTH-1:0] column   [K_H];
    logic [WIN_W-1:0]         win_flat;

    assign accept     = bus.in_valid && bus.in_ready;
    assign win_take   = bus.win_valid && bus.win_ready;
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
    assign win_fire   = accept && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_pixel) state_nxt = FLUSH;
            FLUSH:   if (!bus.win_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; input is stalled whenever an unconsumed window is held.
    always_comb begin
        busy         = (state == RUN) || (state == FLUSH);
        done         = (state == DONE);
        bus.in_ready = (state == RUN) && (!bus.win_valid || bus.win_ready);
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Vertical column ending at the incoming pixel: stored rows plus the new one.
    always_comb begin
        for (int k = 0; k < K_H - 1; k++) column[k] = line_buf[k][col];
        column[K_H-1] = bus.in_pixel;
    end

    // Window after shifting in the new column on the right.
    always_comb begin
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W - 1; c++) win_nxt[r][c] = win_sr[r][c+1];
            win_nxt[r][K_W-1] = column[r];
        end
    end

    // Flatten the next window into the output bus layout.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K_H; r++)
            for (int c = 0; c < K_W; c++)
                win_flat[(r*K_W+c)*IN_DATA_WIDTH +: IN_DATA_WIDTH] = win_nxt[r][c];
    end

    // Line buffers and window shift register advance on every accepted pixel.
    // NOTE: storage arrays carry no reset; stale contents are always
    // overwritten before a window can expose them, and leaving them
    // unreset lets them map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < K_H - 2; k++) line_buf[k][col] <= line_buf[k+1][col];
            line_buf[K_H-2][col] <= bus.in_pixel;
            win_sr <= win_nxt;
        end
    end

    // Output window register: load on a complete window, clear on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.win_out   <= '0;
            bus.win_valid <= 1'b0;
`ifdef WIN_POS_EN
            bus.win_row   <= '0;
            bus.win_col   <= '0;
`endif
        end else if (win_fire) begin
            bus.win_out   <= win_flat;
            bus.win_valid <= 1'b1;
`ifdef WIN_POS_EN
            bus.win_row   <= row - ROW_FIRST_WIN;
            bus.win_col   <= col - COL_FIRST_WIN;
`endif
        end else if (win_take) begin
            bus.win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed testbench for conv_window_gen on a 5x5 image with a 3x3 window.
// Expected windows come from the pixel formula base + row*IMG_W + col.
module tb_conv_window_gen;
    localparam int DW = 9;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int KH = 3;
    localparam int KW = 3;
    localparam int WB = KH * KW * DW;
    localparam int NWC = IW - KW + 1;
    localparam int NWIN = (IH - KH + 1) * NWC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    conv_window_gen_if #(
        .IN_DATA_WIDTH(DW), .K_H(KH), .K_W(KW)
`ifdef WIN_POS_EN
        , .IMG_W(IW), .IMG_H(IH)
`endif
    ) bus ();

    conv_window_gen #(
        .IN_DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .K_H(KH), .K_W(KW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    bit mon_en = 0;
    int mon_base = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    int first_cyc = -1;
    int acc12_cyc = -1;
    bit stall_mode = 0;
    int stalled = 0;
    int stall_seen = 0;
    logic [WB-1:0] first_win;
    logic [WB-1:0] last_win;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WB-1:0] exp_win(input int base, input int k);
        logic [WB-1:0] v;
        int wr;
        int wc;
        v = '0;
        wr = k / NWC;
        wc = k % NWC;
        for (int i = 0; i < KH; i++)
            for (int j = 0; j < KW; j++)
                v[(i*KW+j)*DW +: DW] = DW'(base + (wr + i) * IW + wc + j);
        return v;
    endfunction

    function automatic logic [WB-1:0] pack9(input int a[9]);
        logic [WB-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[i*DW +: DW] = DW'(a[i]);
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Downstream ready: optionally hold off the first window for 3 cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_mode && bus.win_valid && stalled < 3) begin
            bus.win_ready = 1'b0;
            stalled++;
        end else begin
            bus.win_ready = 1'b1;
        end
    end

    // Monitor, sampling at the falling edge.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (bus.in_valid && bus.in_ready && bus.in_pixel == DW'(mon_base + 12) && acc12_cyc < 0)
                acc12_cyc = cycle;
            if (bus.win_valid && first_cyc < 0)
                first_cyc = cycle;
            if (bus.win_valid && !bus.win_ready) begin
                check("stall_hold", bus.win_out, exp_win(mon_base, 0));
                check("stall_in_ready", bus.in_ready, 0);
                stall_seen++;
            end
            if (bus.win_valid && bus.win_ready) begin
                if (win_cnt < NWIN) begin
                    check("win", bus.win_out, exp_win(mon_base, win_cnt));
`ifdef WIN_POS_EN
                    check("win_row", bus.win_row, win_cnt / NWC);
                    check("win_col", bus.win_col, win_cnt % NWC);
`endif
                end else begin
                    check("win_extra", win_cnt, NWIN - 1);
                end
                if (win_cnt == 0) first_win = bus.win_out;
                last_win = bus.win_out;
                win_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_frame(input int base, input int npix, input bit toggle, input bit start_mid);
        int idx;
        int cyc;
        bit acc;
        bit sent_start;
        idx = 0;
        cyc = 0;
        sent_start = 0;
        while (idx < npix && cyc < 400) begin
            bus.in_pixel = DW'(base + idx);
            bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            start = 1'b0;
            if (start_mid && idx == 7 && !sent_start) begin
                start = 1'b1;
                sent_start = 1;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        check("pixels_sent", idx, npix);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = done;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic monitor_arm(input int base, input bit stall);
        mon_base = base;
        win_cnt = 0;
        done_cnt = 0;
        first_cyc = -1;
        acc12_cyc = -1;
        stalled = 0;
        stall_seen = 0;
        stall_mode = stall;
        mon_en = 1;
    endtask

    task automatic run_frame(input int base, input bit toggle, input bit stall,
                             input bit start_mid, input bit chk_consts);
        int fw[9];
        int lw[9];
        monitor_arm(base, stall);
        start_pulse();
        check("busy_run", busy, 1);
        drive_frame(base, IW * IH, toggle, start_mid);
        wait_done();
        @(posedge clk);
        #1;
        check("win_count", win_cnt, NWIN);
        check("done_count", done_cnt, 1);
        check("latency", first_cyc - acc12_cyc, 1);
        check("busy_idle", busy, 0);
        if (stall) check("stall_cycles", stall_seen, 3);
        if (chk_consts) begin
            fw = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
            lw = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
            check("first_win", first_win, pack9(fw));
            check("last_win", last_win, pack9(lw));
        end
        mon_en = 0;
        stall_mode = 0;
    endtask

    task automatic check_idle_outputs(input string phase);
        check({phase, "_in_ready"}, bus.in_ready, 0);
        check({phase, "_win_valid"}, bus.win_valid, 0);
        check({phase, "_busy"}, busy, 0);
        check({phase, "_done"}, done, 0);
        check({phase, "_win_out"}, bus.win_out, 0);
`ifdef WIN_POS_EN
        check({phase, "_win_row"}, bus.win_row, 0);
        check({phase, "_win_col"}, bus.win_col, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_pixel = '0;
        bus.in_valid = 1'b0;
        bus.win_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: plain frame, always ready
        run_frame(0, 0, 0, 0, 1);
        // 2: first window held for 3 cycles
        run_frame(0, 0, 1, 0, 0);
        // 3: in_valid toggling
        run_frame(0, 1, 0, 0, 0);

        // 4: reset after pixel 8, then a clean frame
        monitor_arm(0, 0);
        start_pulse();
        drive_frame(0, 9, 0, 0);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        check("midrst_windows", win_cnt, 0);
        mon_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idle", busy, 0);
        run_frame(0, 0, 0, 0, 1);

        // 5: start pulsed during RUN is ignored
        run_frame(0, 0, 0, 1, 1);

        // 6: two frames back to back with different pixel data
        run_frame(0, 0, 0, 0, 1);
        run_frame(100, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Sliding-window generator that sits directly upstream of the combinational 3x3 convolution unit. It accepts a raster-order pixel stream, stores K_H-1 previous rows in line buffers, and presents every fully-populated K_H x K_W window (stride 1, no padding) as one registered bus with a valid/ready handshake. The convolution unit consumes the bus through a fixed reshape into its window array.

Parameters:
IN_DATA_WIDTH, 9, pixel width in bits; treated as raw bits with no sign interpretation.
IMG_W, 16, image width in pixels; must be >= K_W.
IMG_H, 16, image height in pixels; must be >= K_H.
K_H, 3, window height; supported range 2..5.
K_W, 3, window width; supported range 2..5.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse that begins a frame; accepted only in IDLE.
in_pixel  in  IN_DATA_WIDTH  input pixel, raster order.
in_valid  in  1  in_pixel is valid.
in_ready  out  1  block accepts a pixel this cycle.
win_out  out  K_H*K_W*IN_DATA_WIDTH  window bus; element [r][c] occupies bits (r*K_W+c)*IN_DATA_WIDTH upward; r=0 is the oldest (top) row, c=0 is the leftmost column.
win_valid  out  1  win_out holds a valid window.
win_ready  in  1  downstream consumes the window.
busy  out  1  high in RUN and FLUSH.
done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready, win_valid, busy, done = 0; win_out = 0; row/col counters = 0. Line-buffer contents are don't-care and are never exposed before being rewritten.
- FSM:
  - IDLE: start=1 -> RUN, counters cleared.
  - RUN: a pixel is accepted when in_valid && in_ready. After the pixel at (IMG_H-1, IMG_W-1) is accepted -> FLUSH.
  - FLUSH: stays until win_valid=0, then -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- in_ready = (state==RUN) && (!win_valid || win_ready). A window that is not consumed stalls the input; no pixel or window is dropped.
- On each accepted pixel at (row, col):
  - Shift the pixel into line-buffer column col and the window shift register.
  - Advance col; when col wraps from IMG_W-1 to 0, increment row.
- Window output:
  - If row >= K_H-1 and col >= K_W-1, the window ending at that pixel is loaded into win_out and win_valid=1 on the next clock. Latency is 1 cycle from accept.
  - Otherwise win_valid clears if the current window was consumed that cycle.
- win_out is stable while win_valid && !win_ready.
- A window is consumed when win_valid && win_ready. Consume and a new load in the same cycle is legal: back-to-back throughput is 1 window per clock.
- Windows never span a row wrap: columns 0..K_W-2 of each row produce no output.
- Window count per frame: (IMG_H-K_H+1)*(IMG_W-K_W+1).
- busy=1 in RUN and FLUSH.
- rst asserted mid-frame returns the block to IDLE immediately and discards any partial window. The next frame requires a new start.

Optional Feature:
WIN_POS_EN:
- Defined: adds outputs win_row and win_col, each $clog2(IMG_H) / $clog2(IMG_W) bits wide and registered alongside win_out, giving the window's top-left coordinate. Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. IMG_W=IMG_H=5, K=3, pixels 0..24 streamed with win_ready=1 -> first window is {0,1,2,5,6,7,10,11,12}, one cycle after pixel 12 is accepted; exactly 9 windows; done pulses once; last window is {12,13,14,17,18,19,22,23,24}.
2. Same frame, win_ready held 0 for 3 cycles at the first window -> win_out stays {0..12 set}, in_ready=0 for those cycles, and the full 9-window sequence is unchanged.
3. in_valid toggled 1/0 every cycle -> same 9 windows in the same order; no duplicated window.
4. rst pulsed after pixel 8 -> all outputs 0, state IDLE; a fresh start plus a full frame gives the same result as scenario 1.
5. start pulsed during RUN -> ignored; counters are not reset and the window sequence is unchanged.
6. Two frames back-to-back (start issued the cycle after done) -> the second frame's windows are computed from second-frame pixels only; no first-frame row leaks into them.
